// File: rtl/vend_credit_fsm_if.sv
// Coin-acceptor / dispenser / change-hopper bundle for vend_credit_fsm.
// The controller is the slave. The front-end (or a bench) is the master.
interface vend_credit_fsm_if #(
   parameter int CREDIT_W = 6
);
   logic [1:0]          coin;
   logic                cancel;
   logic                change_ready;
   logic                vend_out;
   logic                change_valid;
   logic [1:0]          change_coin;
   logic                coin_reject;
   logic [CREDIT_W-1:0] credit;
   logic                busy;

   modport slave (
      input  coin, cancel, change_ready,
      output vend_out, change_valid, change_coin, coin_reject, credit, busy
   );

   modport master (
      output coin, cancel, change_ready,
      input  vend_out, change_valid, change_coin, coin_reject, credit, busy
   );
endinterface

// File: rtl/vend_credit_fsm.sv
// Vending controller: accumulates 5/10/20 coins up to PRICE, pulses vend_out,
// returns change over a valid/ready handshake, and supports cancel and idle timeout.
module vend_credit_fsm #(
   parameter int PRICE       = 15,
   parameter int CREDIT_W    = 6,
   parameter int TIMEOUT_CYC = 1000,
   parameter int TO_W        = 10
) (
   input  logic               clk,
   input  logic               rst,
   vend_credit_fsm_if.slave   bus
);
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_VEND    = 2'd2,
      S_REFUND  = 2'd3
   } state_t;

   localparam logic [CREDIT_W-1:0] W_PRICE   = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] W_FIVE    = CREDIT_W'(5);
   localparam logic [CREDIT_W-1:0] W_TEN     = CREDIT_W'(10);
   localparam logic [CREDIT_W-1:0] W_TWENTY  = CREDIT_W'(20);
   localparam logic [TO_W-1:0]     W_TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   state_t              r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [TO_W-1:0]     r_timer;
   logic                r_vend_out;
   logic                r_change_valid;
   logic [1:0]          r_change_coin;
   logic                r_coin_reject;
   logic                r_busy;

   state_t              w_state_next;
   logic [CREDIT_W-1:0] w_credit_next;
   logic [TO_W-1:0]     w_timer_next;
   logic [CREDIT_W-1:0] w_coin_val;
   logic [CREDIT_W-1:0] w_sum;
   logic [CREDIT_W-1:0] w_change_val;
   logic [CREDIT_W-1:0] w_refund_left;
   logic                w_coin_seen;

   always_comb begin
      w_coin_val = '0;
      case (bus.coin)
         2'b01:   w_coin_val = W_FIVE;
         2'b10:   w_coin_val = W_TEN;
         2'b11:   w_coin_val = W_TWENTY;
         default: w_coin_val = '0;
      endcase
   end

   assign w_coin_seen   = (bus.coin != 2'b00);
   assign w_sum         = r_credit + w_coin_val;
   assign w_change_val  = (r_credit >= W_TEN) ? W_TEN : W_FIVE;
   assign w_refund_left = r_credit - w_change_val;

   always_comb begin
      w_state_next  = r_state;
      w_credit_next = r_credit;
      w_timer_next  = r_timer;
      case (r_state)
         S_IDLE: begin
            w_timer_next = '0;
            if (w_coin_seen) begin
               if (w_coin_val >= W_PRICE) begin
                  w_credit_next = w_coin_val - W_PRICE;
                  w_state_next  = S_VEND;
               end else begin
                  w_credit_next = w_coin_val;
                  w_state_next  = S_COLLECT;
               end
            end
         end
         S_COLLECT: begin
            // A completing coin outranks cancel and timeout in the same cycle.
            if (w_coin_seen) begin
               w_timer_next = '0;
               if (w_sum >= W_PRICE) begin
                  w_credit_next = w_sum - W_PRICE;
                  w_state_next  = S_VEND;
               end else begin
                  w_credit_next = w_sum;
                  if (bus.cancel) begin
                     w_state_next = S_REFUND;
                  end
               end
            end else if (bus.cancel) begin
               w_timer_next = '0;
               w_state_next = S_REFUND;
            end else if (r_timer == W_TO_LAST) begin
               w_timer_next = '0;
               w_state_next = S_REFUND;
            end else begin
               w_timer_next = r_timer + 1'b1;
            end
         end
         S_VEND: begin
            w_state_next = (r_credit != '0) ? S_REFUND : S_IDLE;
         end
         S_REFUND: begin
            if (bus.change_ready) begin
               w_credit_next = w_refund_left;
               if (w_refund_left == '0) begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: begin
            w_state_next  = S_IDLE;
            w_credit_next = '0;
            w_timer_next  = '0;
         end
      endcase
   end

   // Outputs are registered from the next-state decode so they line up with r_state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_credit       <= '0;
         r_timer        <= '0;
         r_vend_out     <= 1'b0;
         r_change_valid <= 1'b0;
         r_change_coin  <= 2'b00;
         r_coin_reject  <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_credit       <= w_credit_next;
         r_timer        <= w_timer_next;
         r_vend_out     <= (w_state_next == S_VEND);
         r_change_valid <= (w_state_next == S_REFUND);
         r_change_coin  <= (w_state_next != S_REFUND) ? 2'b00 :
                           (w_credit_next >= W_TEN)   ? 2'b10 : 2'b01;
         r_coin_reject  <= w_coin_seen && ((r_state == S_VEND) || (r_state == S_REFUND));
         r_busy         <= (w_state_next == S_VEND) || (w_state_next == S_REFUND);
      end
   end

   assign bus.vend_out     = r_vend_out;
   assign bus.change_valid = r_change_valid;
   assign bus.change_coin  = r_change_coin;
   assign bus.coin_reject  = r_coin_reject;
   assign bus.credit       = r_credit;
   assign bus.busy         = r_busy;
endmodule

// File: tb/tb_vend_credit_fsm.sv
// Directed bench for vend_credit_fsm: DUT A (PRICE 15, timeout 8) and DUT B (PRICE 5).
module tb_vend_credit_fsm;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic seen_valid;
   logic seen_vend;

   vend_credit_fsm_if #(.CREDIT_W(6)) if_a ();
   vend_credit_fsm_if #(.CREDIT_W(5)) if_b ();

   vend_credit_fsm #(.PRICE(15), .CREDIT_W(6), .TIMEOUT_CYC(8), .TO_W(4)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a.slave)
   );

   vend_credit_fsm #(.PRICE(5), .CREDIT_W(5), .TIMEOUT_CYC(8), .TO_W(4)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      if_a.coin = 2'b00; if_a.cancel = 1'b0; if_a.change_ready = 1'b0;
      if_b.coin = 2'b00; if_b.cancel = 1'b0; if_b.change_ready = 1'b0;
      #12;
      checks++;
      if ({if_a.vend_out, if_a.change_valid, if_a.change_coin, if_a.coin_reject, if_a.busy} !== 6'b0) begin
         errors++; $display("FAIL reset_outs_a got %b exp 000000", {if_a.vend_out, if_a.change_valid, if_a.change_coin, if_a.coin_reject, if_a.busy});
      end
      checks++;
      if (if_a.credit !== 6'd0) begin errors++; $display("FAIL reset_credit_a got %0d exp 0", if_a.credit); end
      checks++;
      if (if_b.credit !== 5'd0 || if_b.busy !== 1'b0) begin
         errors++; $display("FAIL reset_b got credit %0d busy %b exp 0 0", if_b.credit, if_b.busy);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
      $display("reset: released");
   endtask

   task automatic test_exact_price();
      seen_valid = 1'b0;
      if_a.coin = 2'b01; tick();
      checks++;
      if (if_a.credit !== 6'd5 || if_a.vend_out !== 1'b0) begin
         errors++; $display("FAIL t1_credit5 got credit %0d vend %b exp 5 0", if_a.credit, if_a.vend_out);
      end
      tick();
      checks++;
      if (if_a.credit !== 6'd10) begin errors++; $display("FAIL t1_credit10 got %0d exp 10", if_a.credit); end
      tick();
      if_a.coin = 2'b00;
      seen_valid |= if_a.change_valid;
      checks++;
      if (if_a.vend_out !== 1'b1 || if_a.credit !== 6'd0 || if_a.busy !== 1'b1) begin
         errors++; $display("FAIL t1_vend got vend %b credit %0d busy %b exp 1 0 1", if_a.vend_out, if_a.credit, if_a.busy);
      end
      tick();
      seen_valid |= if_a.change_valid;
      checks++;
      if (if_a.vend_out !== 1'b0 || if_a.busy !== 1'b0) begin
         errors++; $display("FAIL t1_idle got vend %b busy %b exp 0 0", if_a.vend_out, if_a.busy);
      end
      checks++;
      if (seen_valid !== 1'b0) begin errors++; $display("FAIL t1_no_change got %b exp 0", seen_valid); end
      $display("test1: 5+5+5 vend done");
   endtask

   task automatic test_change();
      if_a.coin = 2'b11; if_a.change_ready = 1'b1; tick();
      if_a.coin = 2'b00;
      checks++;
      if (if_a.vend_out !== 1'b1 || if_a.credit !== 6'd5 || if_a.change_valid !== 1'b0) begin
         errors++; $display("FAIL t2_vend got vend %b credit %0d valid %b exp 1 5 0", if_a.vend_out, if_a.credit, if_a.change_valid);
      end
      tick();
      checks++;
      if (if_a.change_valid !== 1'b1 || if_a.change_coin !== 2'b01 || if_a.vend_out !== 1'b0) begin
         errors++; $display("FAIL t2_change got valid %b coin %b vend %b exp 1 01 0", if_a.change_valid, if_a.change_coin, if_a.vend_out);
      end
      tick();
      checks++;
      if (if_a.change_valid !== 1'b0 || if_a.credit !== 6'd0 || if_a.busy !== 1'b0 || if_a.change_coin !== 2'b00) begin
         errors++; $display("FAIL t2_done got valid %b credit %0d busy %b coin %b exp 0 0 0 00", if_a.change_valid, if_a.credit, if_a.busy, if_a.change_coin);
      end
      if_a.change_ready = 1'b0;
      $display("test2: coin 20 vend plus 5 change done");
   endtask

   task automatic test_cancel();
      seen_vend = 1'b0;
      if_a.coin = 2'b10; tick();
      if_a.coin = 2'b00; if_a.cancel = 1'b1;
      checks++;
      if (if_a.credit !== 6'd10) begin errors++; $display("FAIL t3_credit got %0d exp 10", if_a.credit); end
      tick();
      if_a.cancel = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seen_vend |= if_a.vend_out;
         checks++;
         if (if_a.change_valid !== 1'b1 || if_a.change_coin !== 2'b10 || if_a.credit !== 6'd10) begin
            errors++; $display("FAIL t3_hold%0d got valid %b coin %b credit %0d exp 1 10 10", i, if_a.change_valid, if_a.change_coin, if_a.credit);
         end
         if (i == 4) if_a.change_ready = 1'b1;
         tick();
      end
      if_a.change_ready = 1'b0;
      seen_vend |= if_a.vend_out;
      checks++;
      if (if_a.change_valid !== 1'b0 || if_a.credit !== 6'd0 || if_a.busy !== 1'b0) begin
         errors++; $display("FAIL t3_done got valid %b credit %0d busy %b exp 0 0 0", if_a.change_valid, if_a.credit, if_a.busy);
      end
      checks++;
      if (seen_vend !== 1'b0) begin errors++; $display("FAIL t3_no_vend got %b exp 0", seen_vend); end
      $display("test3: cancel refund of 10 done");
   endtask

   task automatic test_timeout();
      if_a.coin = 2'b01; tick();
      if_a.coin = 2'b00;
      for (int k = 1; k <= 7; k++) begin
         tick();
         checks++;
         if (if_a.change_valid !== 1'b0 || if_a.busy !== 1'b0) begin
            errors++; $display("FAIL t4_wait%0d got valid %b busy %b exp 0 0", k, if_a.change_valid, if_a.busy);
         end
      end
      tick();
      checks++;
      if (if_a.change_valid !== 1'b1 || if_a.change_coin !== 2'b01 || if_a.credit !== 6'd5) begin
         errors++; $display("FAIL t4_refund got valid %b coin %b credit %0d exp 1 01 5", if_a.change_valid, if_a.change_coin, if_a.credit);
      end
      if_a.change_ready = 1'b1; tick();
      if_a.change_ready = 1'b0;
      checks++;
      if (if_a.change_valid !== 1'b0 || if_a.credit !== 6'd0) begin
         errors++; $display("FAIL t4_done got valid %b credit %0d exp 0 0", if_a.change_valid, if_a.credit);
      end
      $display("test4: timeout refund done");
   endtask

   task automatic test_reject();
      if_b.coin = 2'b11; if_b.change_ready = 1'b0; tick();
      if_b.coin = 2'b00;
      checks++;
      if (if_b.vend_out !== 1'b1 || if_b.credit !== 5'd15) begin
         errors++; $display("FAIL t5_vend got vend %b credit %0d exp 1 15", if_b.vend_out, if_b.credit);
      end
      tick();
      if_b.coin = 2'b10;
      checks++;
      if (if_b.change_valid !== 1'b1 || if_b.change_coin !== 2'b10) begin
         errors++; $display("FAIL t5_first got valid %b coin %b exp 1 10", if_b.change_valid, if_b.change_coin);
      end
      tick();
      if_b.coin = 2'b00;
      checks++;
      if (if_b.coin_reject !== 1'b1 || if_b.credit !== 5'd15 || if_b.change_coin !== 2'b10) begin
         errors++; $display("FAIL t5_reject got rej %b credit %0d coin %b exp 1 15 10", if_b.coin_reject, if_b.credit, if_b.change_coin);
      end
      tick();
      if_b.change_ready = 1'b1;
      checks++;
      if (if_b.coin_reject !== 1'b0 || if_b.credit !== 5'd15) begin
         errors++; $display("FAIL t5_rej_pulse got rej %b credit %0d exp 0 15", if_b.coin_reject, if_b.credit);
      end
      tick();
      checks++;
      if (if_b.change_valid !== 1'b1 || if_b.change_coin !== 2'b01 || if_b.credit !== 5'd5) begin
         errors++; $display("FAIL t5_second got valid %b coin %b credit %0d exp 1 01 5", if_b.change_valid, if_b.change_coin, if_b.credit);
      end
      tick();
      if_b.change_ready = 1'b0;
      checks++;
      if (if_b.change_valid !== 1'b0 || if_b.credit !== 5'd0 || if_b.busy !== 1'b0) begin
         errors++; $display("FAIL t5_done got valid %b credit %0d busy %b exp 0 0 0", if_b.change_valid, if_b.credit, if_b.busy);
      end
      $display("test5: reject while refunding done");
   endtask

   task automatic test_async_reset();
      if_a.coin = 2'b11; if_a.change_ready = 1'b0; tick();
      if_a.coin = 2'b00; tick();
      checks++;
      if (if_a.change_valid !== 1'b1 || if_a.credit !== 6'd5) begin
         errors++; $display("FAIL t6_pre got valid %b credit %0d exp 1 5", if_a.change_valid, if_a.credit);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({if_a.vend_out, if_a.change_valid, if_a.change_coin, if_a.coin_reject, if_a.busy} !== 6'b0 || if_a.credit !== 6'd0) begin
         errors++; $display("FAIL t6_async got outs %b credit %0d exp 000000 0", {if_a.vend_out, if_a.change_valid, if_a.change_coin, if_a.coin_reject, if_a.busy}, if_a.credit);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
      if_a.coin = 2'b01; tick();
      if_a.coin = 2'b00;
      checks++;
      if (if_a.credit !== 6'd5 || if_a.busy !== 1'b0 || if_a.change_valid !== 1'b0) begin
         errors++; $display("FAIL t6_after got credit %0d busy %b valid %b exp 5 0 0", if_a.credit, if_a.busy, if_a.change_valid);
      end
      $display("test6: async reset mid-refund done");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_exact_price();
      test_change();
      test_cancel();
      test_timeout();
      test_reject();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/vend_credit_fsm.md
Name: vend_credit_fsm

Overview:
Parametrised vending controller, successor to the single-price 5/10 coin machine. Accepts 5/10/20-unit coins and accumulates credit up to a configurable price. Dispenses one item and returns change through a valid/ready coin-return handshake. Adds cancel, inactivity timeout and rejection of coins while busy. Sits between the coin acceptor front-end and the dispenser/change hopper.

Parameters:
PRICE, 15, item price in units; must be a multiple of 5 and at least 5.
CREDIT_W, 6, credit register width; must hold PRICE+15 (legal range: PRICE+15 <= 2^CREDIT_W-1).
TIMEOUT_CYC, 1000, idle cycles in COLLECT before automatic refund; must be at least 1.
TO_W, 10, timeout counter width; must hold TIMEOUT_CYC.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
coin  in  2  coin code sampled each clk: 00 none, 01 = 5, 10 = 10, 11 = 20.
cancel  in  1  level; request refund of current credit.
change_ready  in  1  hopper accepts the presented change coin.
vend_out  out  1  one-cycle pulse; dispense one item.
change_valid  out  1  change coin presented.
change_coin  out  2  change coin code: 01 = 5, 10 = 10; 00 when change_valid is 0.
coin_reject  out  1  one-cycle pulse; coin seen while busy is returned unaccepted.
credit  out  CREDIT_W  current credit register value.
busy  out  1  high in VEND or REFUND.

Behaviour:
- All outputs are registered.
- rst low clears all state and outputs immediately, without waiting for clk: state IDLE, credit 0, timer 0, vend_out 0, change_valid 0, change_coin 00, coin_reject 0, busy 0.
- Reset asserted mid-REFUND discards the outstanding credit.
- States: IDLE, COLLECT, VEND, REFUND.
- IDLE (credit = 0):
  - A non-zero coin makes sum = coin value.
  - If sum >= PRICE, go to VEND. Otherwise go to COLLECT with credit = sum.
  - cancel is ignored.
- COLLECT:
  - Each non-zero coin makes sum = credit + value, and the timer clears.
  - If sum >= PRICE: credit <= sum - PRICE and go to VEND. This takes priority over cancel and timeout in the same cycle.
  - Otherwise, if cancel: credit <= sum and go to REFUND (a coin arriving with cancel is still counted).
  - Otherwise, with no coin: timer increments. When timer reaches TIMEOUT_CYC-1, go to REFUND.
- VEND:
  - Lasts exactly one cycle with vend_out = 1.
  - vend_out rises in the cycle after the clk edge that sampled the completing coin (latency 1).
  - Next state is REFUND if credit > 0, otherwise IDLE.
- REFUND:
  - change_valid = 1. change_coin = 10 if credit >= 10, else 01.
  - change_coin is held stable while change_valid is high and change_ready is low.
  - On change_valid & change_ready: credit <= credit - coin value. If the result is 0, change_valid drops the next cycle and state goes to IDLE; otherwise the next coin is presented back-to-back.
- A non-zero coin in VEND or REFUND pulses coin_reject for one cycle (the cycle after sampling) and leaves credit unchanged.
- cancel in VEND or REFUND is ignored.
- Credit arithmetic is unsigned, with no wrap-around possible under the parameter constraint.
- Unused coin/state encodings go to IDLE.

Test Plan:
1. PRICE=15; coins 5, 5, 5 on consecutive cycles -> credit 5, 10; vend_out high for 1 cycle after the third coin; credit 0; back to IDLE; change_valid never asserted.
2. Single coin 20, change_ready=1 -> vend_out pulse; then change_valid=1 with change_coin=01 for 1 cycle; credit 5 -> 0; IDLE.
3. Coin 10, then cancel with change_ready=0 for 4 cycles, then 1 -> change_coin=10 held stable for 5 cycles; single transfer; credit 0; no vend_out.
4. TIMEOUT_CYC=8; coin 5, then no activity -> REFUND entered 8 cycles after the coin; one 5-unit change coin returned.
5. PRICE=5; coin 20 with change_ready=0, plus coin 10 during REFUND -> coin_reject pulse; credit stays 15; after ready, change sequence is 10 then 5.
6. rst driven low mid-REFUND between clk edges -> all outputs 0 immediately; after release, a coin of 5 is accepted normally.
